// File: rtl/i2c_cmd_queue.sv
// Buffered command front end for i2c_master_write: two prioritised ready/valid
// producers feed one FIFO, drained by a valid/busy dispatcher toward the slow master.
module i2c_cmd_queue #(
  parameter int DEPTH       = 16,
  parameter int PTR_W       = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int GAP_CYCLES  = 250
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [6:0]       i_a_addr,
  input  logic [7:0]       i_a_data,
  input  logic             i_a_RW,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [6:0]       i_b_addr,
  input  logic [7:0]       i_b_data,
  input  logic             i_b_RW,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  output logic [6:0]       o_addr,
  output logic [7:0]       o_data,
  output logic             o_RW,
  output logic             o_valid,
  input  logic             i_busy,
  output logic [PTR_W:0]   o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_timeout
);

  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             push_cmd;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_next;
  logic             push_a;
  logic             push_b;
  logic             push;
  logic             pop;
  logic             busy_meta;
  logic             busy_s;
  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // Port A always wins; B is held off whenever A is offering, even if A stalls.
  assign o_a_ready = !o_full;
  assign o_b_ready = !o_full && !i_a_valid;
  assign push_a    = i_a_valid && o_a_ready;
  assign push_b    = i_b_valid && o_b_ready;
  assign push      = push_a || push_b;
  assign head      = mem[rd_ptr];
  assign pop       = (state == IDLE) && !o_empty && !busy_s && (gap_cnt == '0);

  // NOTE: every variable in always_comb gets a default first so no latch is inferred.
  always_comb begin
    push_cmd = '{rw: i_b_RW, addr: i_b_addr, data: i_b_data};
    if (push_a) push_cmd = '{rw: i_a_RW, addr: i_a_addr, data: i_a_data};
  end

  always_comb begin
    count_next = o_count;
    case ({push, pop})
      2'b10:   count_next = o_count + 1'b1;
      2'b01:   count_next = o_count - 1'b1;
      default: count_next = o_count;
    endcase
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_count <= count_next;
      o_empty <= (count_next == '0);
      o_full  <= (count_next == (PTR_W+1)'(DEPTH));
    end
  end

  // i_busy comes from the master's clock domain; only busy_s is ever used.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= i_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= IDLE;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_addr    <= '0;
      o_data    <= '0;
      o_RW      <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (pop) begin
            o_addr  <= head.addr;
            o_data  <= head.data;
            o_RW    <= head.rw;
            o_valid <= 1'b1;
            to_cnt  <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (busy_s) begin
            o_valid <= 1'b0;
            state   <= WAIT_DONE;
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            // The master never answered: drop the command rather than re-queue it.
            o_valid   <= 1'b0;
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy_s) begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Self-checking bench for i2c_cmd_queue: producers push to a scoreboard on
// acceptance, a small master model pops and compares on each dispatch.
module tb_i2c_cmd_queue;

  localparam int DEPTH       = 16;
  localparam int PTR_W       = 4;
  localparam int ACK_TIMEOUT = 1024;
  localparam int GAP_CYCLES  = 250;

  logic           clk = 1'b0;
  logic           reset_p = 1'b1;
  logic [6:0]     i_a_addr = '0;
  logic [7:0]     i_a_data = '0;
  logic           i_a_RW = 1'b0;
  logic           i_a_valid = 1'b0;
  logic           o_a_ready;
  logic [6:0]     i_b_addr = '0;
  logic [7:0]     i_b_data = '0;
  logic           i_b_RW = 1'b0;
  logic           i_b_valid = 1'b0;
  logic           o_b_ready;
  logic [6:0]     o_addr;
  logic [7:0]     o_data;
  logic           o_RW;
  logic           o_valid;
  logic           i_busy = 1'b0;
  logic [PTR_W:0] o_count;
  logic           o_empty;
  logic           o_full;
  logic           o_timeout;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_fall = 0;
  bit          gap_armed = 0;
  logic [15:0] sb[$];
  logic [7:0]  log_q[$];

  i2c_cmd_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset_p(reset_p),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_RW(i_a_RW),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_RW(i_b_RW),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
    .o_addr(o_addr), .o_data(o_data), .o_RW(o_RW), .o_valid(o_valid),
    .i_busy(i_busy), .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offer one command on port A (port=0) or B (port=1) until accepted.
  task automatic push(input bit port, input logic [6:0] a, input logic [7:0] d,
                      input logic rw, output int acc);
    bit rdy;
    bit done;
    acc  = -1;
    done = 0;
    if (!port) begin
      i_a_addr = a; i_a_data = d; i_a_RW = rw; i_a_valid = 1'b1;
    end else begin
      i_b_addr = a; i_b_data = d; i_b_RW = rw; i_b_valid = 1'b1;
    end
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (port && i_a_valid) check("b_ready_blocked", o_b_ready, 0);
      rdy = port ? o_b_ready : o_a_ready;
      @(posedge clk); #1;
      if (rdy) begin
        done = 1;
        acc  = cyc;
        sb.push_back({rw, a, d});
      end
    end
    if (!port) i_a_valid = 1'b0;
    else       i_b_valid = 1'b0;
    check("push_accepted", done, 1);
  endtask

  // Master model: wait for a request, compare it, answer with a busy pulse.
  task automatic serve_one(input int hold, output int seen);
    bit          ok;
    int          n;
    logic [15:0] exp;
    seen = -1;
    ok   = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_valid) begin ok = 1; break; end
    end
    check("dispatch_seen", ok, 1);
    if (!ok) return;
    seen = cyc;
    if (gap_armed) check("gap_min", (cyc - last_fall) >= GAP_CYCLES, 1);
    exp = 16'hxxxx;
    if (sb.size() > 0) exp = sb.pop_front();
    check("payload", {o_RW, o_addr, o_data}, exp);
    log_q.push_back(o_data);
    i_busy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!o_valid) break;
    end
    check("busy_ack_latency", n, 3);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    i_busy    = 1'b0;
    last_fall = cyc;
    gap_armed = 1;
  endtask

  initial begin
    int acc;
    int seen;
    int first_pop;
    int acc17;
    int rise;
    int tcyc;
    int pulses;
    bit stale;
    logic [7:0] order_exp[4];

    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_payload", {o_RW, o_addr, o_data}, 0);
    check("rst_a_ready", o_a_ready, 1);

    // Single command: latency, payload, busy handshake, held payload.
    @(posedge clk); #1;
    push(0, 7'h27, 8'h3C, 1'b0, acc);
    @(negedge clk);
    check("lat_edge_n", o_valid, 0);
    @(negedge clk);
    check("lat_edge_n1", o_valid, 1);
    serve_one(4, seen);
    check("payload_held", {o_RW, o_addr, o_data}, {1'b0, 7'h27, 8'h3C});
    check("valid_low_after", o_valid, 0);

    // Both ports active: A drains first, B afterwards, while the gap is enforced.
    log_q.delete();
    @(posedge clk); #1;
    fork
      begin
        push(0, 7'h10, 8'h01, 1'b0, acc);
        push(0, 7'h11, 8'h02, 1'b1, acc);
        push(0, 7'h12, 8'h03, 1'b0, acc);
      end
      push(1, 7'h20, 8'hF0, 1'b1, acc);
      for (int k = 0; k < 4; k++) serve_one(3, seen);
    join
    order_exp = '{8'h01, 8'h02, 8'h03, 8'hF0};
    check("order_len", log_q.size(), 4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) check("order", log_q[k], order_exp[k]);

    // Fill to DEPTH under busy, then offer a 17th while the first pop happens.
    @(negedge clk);
    i_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++)
      push(0, 7'(7'h40 + k), 8'(8'hA0 + k), k[0], acc);
    @(negedge clk);
    check("full_flag", o_full, 1);
    check("full_count", o_count, DEPTH);
    check("full_a_ready", o_a_ready, 0);
    check("full_not_empty", o_empty, 0);
    first_pop = -1;
    acc17     = -1;
    fork
      push(0, 7'h7F, 8'h5A, 1'b1, acc17);
      begin
        repeat (5) @(negedge clk);
        check("held_count", o_count, DEPTH);
        check("held_a_ready", o_a_ready, 0);
        i_busy = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
          serve_one(2, seen);
          if (k == 0) first_pop = seen;
          check("count_bound", o_count <= DEPTH, 1);
        end
      end
    join
    check("push_after_pop", acc17, first_pop + 1);
    check("drained_empty", o_empty, 1);

    // Timeout: nobody answers the first request; the second follows immediately.
    @(posedge clk); #1;
    push(0, 7'h11, 8'h55, 1'b0, acc);
    push(0, 7'h12, 8'h66, 1'b1, acc);
    rise = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_valid) begin rise = cyc; break; end
    end
    check("to_dispatch", rise >= 0, 1);
    pulses = 0;
    tcyc   = -1;
    for (int i = 0; i < ACK_TIMEOUT + 4; i++) begin
      @(negedge clk);
      if (o_timeout) begin
        pulses++;
        tcyc = cyc;
        check("to_valid_low", o_valid, 0);
      end
    end
    check("to_pulses", pulses, 1);
    check("to_cycle", tcyc - rise, ACK_TIMEOUT);
    if (sb.size() > 0) void'(sb.pop_front());
    serve_one(2, seen);

    // Reset while a request is outstanding and five more are queued.
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) push(0, 7'(7'h30 + k), 8'(8'hC0 + k), 1'b0, acc);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    check("pre_rst_valid", o_valid, 1);
    check("pre_rst_count", o_count, 5);
    reset_p = 1'b1;
    @(posedge clk); #1;
    reset_p = 1'b0;
    sb.delete();
    gap_armed = 0;
    @(negedge clk);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_empty", o_empty, 1);
    stale = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_valid) stale = 1;
    end
    check("no_stale", stale, 0);
    @(posedge clk); #1;
    push(1, 7'h55, 8'h99, 1'b1, acc);
    serve_one(2, seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_queue.md
Name: i2c_cmd_queue

Overview:
- Buffered command front end for i2c_master_write. It replaces the combinational empty-select mux between the LCD init-sequence source and the keypad source.
- Two ready/valid producer ports (A = init/register sequence, B = keypad translator) push {RW, addr, data} commands into one FIFO.
- A dispatcher pops commands one at a time and hands them to the master using a valid/busy handshake that crosses into the master's slow clock.
- Runs entirely on the system clock.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- PTR_W, 4, log2(DEPTH).
- ACK_TIMEOUT, 1024, system cycles o_valid may stay high without i_busy being seen before the command is abandoned.
- GAP_CYCLES, 250, minimum idle system cycles after i_busy falls before the next dispatch. This is at least one master clock period (244 cycles).

Ports:
- clk  in  1  system clock
- reset_p  in  1  synchronous active-high reset
- i_a_addr  in  7  port A 7-bit slave address
- i_a_data  in  8  port A data byte
- i_a_RW  in  1  port A read/write bit
- i_a_valid  in  1  port A command valid
- o_a_ready  out  1  port A accept
- i_b_addr  in  7  port B address
- i_b_data  in  8  port B data
- i_b_RW  in  1  port B read/write bit
- i_b_valid  in  1  port B command valid
- o_b_ready  out  1  port B accept
- o_addr  out  7  command address to master
- o_data  out  8  command data to master
- o_RW  out  1  command read/write bit to master
- o_valid  out  1  command request to master
- i_busy  in  1  master busy (slow-clock domain, asynchronous here)
- o_count  out  PTR_W+1  entries currently stored
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_timeout  out  1  one-cycle pulse when a command is abandoned

Behaviour:
- Clock and reset: one clock, clk. reset_p is synchronous and active-high. Reset is sampled on the rising edge of clk only.
- Reset values:
  - FIFO pointers, o_count, o_valid, o_timeout, o_addr, o_data, o_RW all 0.
  - o_empty = 1, o_full = 0.
  - FSM in IDLE; gap and timeout counters 0; busy synchronizer flops 0.
- Reset mid-operation: any in-flight command and all queued entries are discarded. o_valid is 0 from the first edge after reset_p is high.
- Entry format: {RW, addr[6:0], data[7:0]}, 16 bits. Storage is a register array.
- Push arbitration: fixed priority, A over B, at most one push per cycle.
  - o_a_ready = !o_full.
  - o_b_ready = !o_full && !i_a_valid.
  - A push occurs when valid && ready on the rising edge.
  - Producers hold valid and payload until accepted. No entry is ever dropped on the push side.
- Status:
  - o_full and o_empty are registered and derived from the next-state count.
  - o_full blocks pushes even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves o_count unchanged.
  - Pointers wrap modulo DEPTH. o_count reaches DEPTH at full.
- Busy synchronization: i_busy passes through a 2-flop synchronizer to give busy_s. All FSM decisions use busy_s.
- Dispatcher FSM:
  - IDLE: if !o_empty && !busy_s && gap counter == 0, pop the head into o_addr/o_data/o_RW, set o_valid = 1, clear the timeout counter, and go to REQ.
  - REQ: o_valid and payload are held stable.
    - If busy_s = 1: o_valid <= 0, go to WAIT_DONE.
    - Else if the timeout counter reaches ACK_TIMEOUT-1: o_valid <= 0, pulse o_timeout for 1 cycle, go to IDLE. The command is lost, not re-queued.
    - Otherwise increment the timeout counter.
  - WAIT_DONE: when busy_s = 0, load the gap counter with GAP_CYCLES and go to IDLE. The gap counter decrements to 0 while in IDLE.
- Latency: a push into an empty, idle queue at edge N gives o_valid = 1 after edge N+1. The payload equals the pushed entry.
- Payload outputs keep their last value after o_valid falls.
- Ordering: strict FIFO order of acceptance, regardless of source port.

Test Plan:
- Reset, then push one A command {RW=0, addr=0x27, data=0x3C} at edge N → o_valid=1 after edge N+1 with o_addr=0x27, o_data=0x3C, o_RW=0. Raise i_busy → o_valid=0 three edges later (2-flop sync + FSM). Drop i_busy → next dispatch no sooner than GAP_CYCLES later.
- i_a_valid and i_b_valid both high for 3 cycles with distinct data (A: 0x01, 0x02, 0x03 held in turn; B: 0xF0) → o_b_ready stays 0 while i_a_valid is high. Dispatch order is 0x01, 0x02, 0x03, then 0xF0.
- Hold i_busy=1, push 17 commands with DEPTH=16 → o_full=1 and o_count=16 after the 16th; the 17th is held with ready=0. Release busy and model the master → all 17 emerge in order with no loss.
- Full FIFO with a pop in progress and a push offered the same cycle → push refused that cycle and accepted the next. o_count never exceeds 16.
- Keep i_busy=0 after o_valid rises → o_timeout pulses exactly once, ACK_TIMEOUT cycles after o_valid rose. o_valid falls and the next entry is dispatched.
- Assert reset_p while in REQ with 5 entries queued → after that edge o_valid=0, o_count=0, o_empty=1. No stale command is dispatched afterwards.
